sobel_window_feeder: RTL and testbench
======================================

# sobel_window_feeder

Upstream sequencer for the `hybrid_mac` accumulator in the edge-detection datapath. It accepts one 3x3 pixel window plus a kernel select (Sobel Gx or Gy). It clears the MAC, streams the nine activation/weight pairs into it one per cycle, and waits out the MAC latency. It then captures `mac_result` and presents the signed gradient on a valid/ready output.

## Interface

Parameters
- `MAC_LAT`, default 2: cycles from a pair appearing on `activation`/`weight` to its inclusion in `mac_result`.
- `ACC_W`, default 32: accumulator width, matching `mac_result`.

Ports
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `win_valid` in 1: window offered.
- `win_ready` out 1: feeder can accept a window.
- `win_pixels` in 72: nine unsigned 8-bit pixels, raster order. `p0` (top-left) is at [7:0], `p8` (bottom-right) at [71:64].
- `kernel_sel` in 1: 0 = Gx, 1 = Gy. Sampled with the window.
- `mac_clr` out 1: drives the `hybrid_mac` reset (accumulator clear).
- `activation` out 8: MAC activation.
- `weight` out 8: MAC weight, two's complement.
- `mac_result` in ACC_W: MAC accumulated result.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_data` out ACC_W: signed gradient.
- `res_kernel` out 1: the `kernel_sel` value belonging to `res_data`.

## Operation

- The MAC is signed 8x8, so pixels are halved on issue.
  - `activation = {1'b0, pixel[7:1]}`, range 0..127.
- Kernels, raster order:
  - Gx = -1 0 1 / -2 0 2 / -1 0 1
  - Gy = -1 -2 -1 / 0 0 0 / 1 2 1
  - Encoding: -1 = 8'hFF, -2 = 8'hFE.
- All nine taps are always issued, including zero-weight taps, so the sequence length is fixed.
- FSM states and transitions:
  - IDLE
    - Outputs: `win_ready`=1, `mac_clr`=1, `activation`=`weight`=0.
    - On `win_valid && win_ready`: latch pixels and `kernel_sel` → CLEAR.
  - CLEAR
    - One cycle. `mac_clr`=1, `activation`=`weight`=0 → FEED.
  - FEED
    - Nine cycles. Tap counter k = 0..8; `mac_clr`=0.
    - Drives `activation` from latched pixel k and `weight` from kernel[k].
    - After k=8 → DRAIN.
  - DRAIN
    - `MAC_LAT` cycles. `mac_clr`=0, `activation`=`weight`=0.
    - On the last DRAIN edge, register `mac_result` into `res_data` and the latched select into `res_kernel` → HOLD.
  - HOLD
    - `res_valid`=1; `res_data` and `res_kernel` held stable; `mac_clr`=0.
    - On `res_ready` → IDLE.
- `win_ready` is 1 only in IDLE. Input changes outside IDLE are ignored; only the latched window is used.
- `res_data` is passed through at full `ACC_W`; no saturation or absolute value. The worst case is ±508, so it cannot overflow.

## Timing

- Window accepted on edge t:
  - CLEAR occupies cycle t+1.
  - Taps 0..8 are driven in cycles t+2..t+10.
  - DRAIN occupies t+11..t+10+`MAC_LAT`.
  - `res_valid` rises in cycle t+11+`MAC_LAT` (13 cycles after acceptance for `MAC_LAT`=2).
- Result handshake completes on the edge where `res_valid && res_ready`.
  - `win_ready`=1 in the following cycle.
  - Minimum period is 12+`MAC_LAT` cycles per window.
- Reset values while `reset` is asserted: state IDLE, `win_ready`=1, `mac_clr`=1, `activation`=0, `weight`=0, `res_valid`=0, `res_data`=0, `res_kernel`=0, tap counter 0.
- Reset mid-operation, any state: the sequence is abandoned immediately and no partial result is emitted. The next window starts from a cleared MAC.
- `res_ready` held low: HOLD persists indefinitely and outputs stay frozen.
- `res_ready` high on entry to HOLD: `res_valid` is still high for exactly one cycle.

## Structure

- Shared package `sobel_pkg` holds:
  - state enum `{IDLE, CLEAR, FEED, DRAIN, HOLD}`;
  - `TAPS` = 9;
  - `GX_K` / `GY_K` constant arrays of 8-bit signed weights;
  - pixel and weight width constants.
- One sub-module, `sobel_kernel_rom`, combinational: (`kernel_sel`, tap index 0..8) → 8-bit weight.
- The top level holds the FSM, the window/select latch, the tap counter, the drain counter and the result registers.

## Test plan

- Flat window, all pixels 100:
  - Gx → `res_data`=0.
  - Gy → `res_data`=0.
- Vertical edge, left column 0, right column 254:
  - Gx → `res_data`=508.
  - Gy → `res_data`=0, `res_kernel`=1.
- Horizontal edge, top row 254, bottom row 0:
  - Gy → `res_data`=-508 (32'hFFFFFE04).
  - Tap sequence on `weight` is FF,FE,FF,00,00,00,01,02,01.
- Backpressure: `res_ready` low for 5 cycles.
  - `res_valid` stays 1, `res_data` is stable, `win_ready`=0 throughout.
  - After the handshake, `win_ready`=1 on the next cycle.
  - Window-accept to `res_valid` is exactly 13 cycles for `MAC_LAT`=2.
- Async reset pulse during FEED tap 4:
  - All outputs take their reset values immediately.
  - A following flat-100 Gx window returns 0, proving no carry-over.
- `win_valid` held high with `win_pixels` changing during FEED/DRAIN:
  - The result matches the originally latched window.
  - No second window is accepted until IDLE.

Source files
------------

// File: rtl/sobel_window_feeder_pkg.sv
// Shared types and constants for the Sobel window feeder: FSM states,
// tap count, data widths and the two 3x3 gradient kernels in raster order.
package sobel_pkg;

  localparam int TAPS  = 9;
  localparam int PIX_W = 8;
  localparam int WGT_W = 8;
  localparam int TAP_W = 4;
  localparam int WIN_W = TAPS * PIX_W;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    HOLD
  } state_t;

  localparam logic signed [WGT_W-1:0] GX_K [TAPS] = '{
    8'hFF, 8'h00, 8'h01,
    8'hFE, 8'h00, 8'h02,
    8'hFF, 8'h00, 8'h01
  };

  localparam logic signed [WGT_W-1:0] GY_K [TAPS] = '{
    8'hFF, 8'hFE, 8'hFF,
    8'h00, 8'h00, 8'h00,
    8'h01, 8'h02, 8'h01
  };

  // The MAC multiplies signed 8x8, so pixels lose their LSB to stay positive.
  function automatic logic [PIX_W-1:0] halve_pixel(input logic [PIX_W-1:0] p);
    return p >> 1;
  endfunction

endpackage

// File: rtl/sobel_window_feeder_if.sv
// Window input, MAC drive/feedback and result output of the Sobel feeder.
// Handshakes: a transfer happens on the rising edge where valid && ready are both 1.
interface sobel_window_feeder_if #(
  parameter int ACC_W = 32
) ();
  import sobel_pkg::*;

  logic                 win_valid;
  logic                 win_ready;
  logic [WIN_W-1:0]     win_pixels;
  logic                 kernel_sel;

  logic                 mac_clr;
  logic [PIX_W-1:0]     activation;
  logic [WGT_W-1:0]     weight;
  logic [ACC_W-1:0]     mac_result;

  logic                 res_valid;
  logic                 res_ready;
  logic [ACC_W-1:0]     res_data;
  logic                 res_kernel;

  state_t               dbg_state;
  logic [TAP_W-1:0]     dbg_tap;

  modport slave (
    input  win_valid, win_pixels, kernel_sel, mac_result, res_ready,
    output win_ready, mac_clr, activation, weight,
    output res_valid, res_data, res_kernel, dbg_state, dbg_tap
  );

  modport master (
    output win_valid, win_pixels, kernel_sel, mac_result, res_ready,
    input  win_ready, mac_clr, activation, weight,
    input  res_valid, res_data, res_kernel, dbg_state, dbg_tap
  );

endinterface

// File: rtl/sobel_window_feeder_kernel_rom.sv
// Combinational weight lookup: kernel select (0 = Gx, 1 = Gy) and tap 0..8
// to an 8-bit two's-complement weight; out-of-range taps read as zero.
module sobel_kernel_rom
  import sobel_pkg::*;
(
  input  logic             kernel_sel_i,
  input  logic [TAP_W-1:0] tap_i,
  output logic [WGT_W-1:0] weight_o
);

  always_comb begin
    weight_o = '0;
    if (tap_i < TAP_W'(TAPS)) begin
      weight_o = kernel_sel_i ? GY_K[tap_i] : GX_K[tap_i];
    end
  end

endmodule

// File: rtl/sobel_window_feeder.sv
// Sequencer that clears the MAC, streams nine pixel/weight taps into it,
// waits out its latency and presents the captured gradient on a valid/ready port.
module sobel_window_feeder
  import sobel_pkg::*;
#(
  parameter int MAC_LAT = 2,
  parameter int ACC_W   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  sobel_window_feeder_if.slave   bus
);

  localparam int DRN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(MAC_LAT - 1);
  localparam logic [TAP_W-1:0] TAP_LAST   = TAP_W'(TAPS - 1);

  state_t             state_q;
  logic [PIX_W-1:0]   pix_q [TAPS];
  logic               sel_q;
  logic [TAP_W-1:0]   tap_q;
  logic [DRN_W-1:0]   drain_q;

  logic               win_ready_q;
  logic               mac_clr_q;
  logic [PIX_W-1:0]   act_q;
  logic [WGT_W-1:0]   wgt_q;
  logic               res_valid_q;
  logic [ACC_W-1:0]   res_data_q;
  logic               res_kernel_q;

  logic [TAP_W-1:0]   tap_d;
  logic [PIX_W-1:0]   pix_d;
  logic [WGT_W-1:0]   wgt_d;

  // Outputs are registered, so the tap to be driven next cycle is looked up now.
  always_comb begin
    tap_d = '0;
    if (state_q == FEED) begin
      tap_d = tap_q + TAP_W'(1);
    end
  end

  always_comb begin
    pix_d = '0;
    if (tap_d < TAP_W'(TAPS)) begin
      pix_d = pix_q[tap_d];
    end
  end

  sobel_kernel_rom u_rom (
    .kernel_sel_i (sel_q),
    .tap_i        (tap_d),
    .weight_o     (wgt_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      for (int i = 0; i < TAPS; i++) pix_q[i] <= '0;
      sel_q        <= 1'b0;
      tap_q        <= '0;
      drain_q      <= '0;
      win_ready_q  <= 1'b1;
      mac_clr_q    <= 1'b1;
      act_q        <= '0;
      wgt_q        <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_kernel_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.win_valid && win_ready_q) begin
            for (int i = 0; i < TAPS; i++) pix_q[i] <= bus.win_pixels[i*PIX_W +: PIX_W];
            sel_q       <= bus.kernel_sel;
            win_ready_q <= 1'b0;
            state_q     <= CLEAR;
          end
        end
        CLEAR: begin
          mac_clr_q <= 1'b0;
          tap_q     <= tap_d;
          act_q     <= halve_pixel(pix_d);
          wgt_q     <= wgt_d;
          state_q   <= FEED;
        end
        FEED: begin
          if (tap_q == TAP_LAST) begin
            tap_q   <= '0;
            drain_q <= '0;
            act_q   <= '0;
            wgt_q   <= '0;
            state_q <= DRAIN;
          end else begin
            tap_q <= tap_d;
            act_q <= halve_pixel(pix_d);
            wgt_q <= wgt_d;
          end
        end
        DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            res_valid_q  <= 1'b1;
            res_data_q   <= bus.mac_result;
            res_kernel_q <= sel_q;
            state_q      <= HOLD;
          end else begin
            drain_q <= drain_q + DRN_W'(1);
          end
        end
        HOLD: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            win_ready_q <= 1'b1;
            mac_clr_q   <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          win_ready_q <= 1'b1;
          mac_clr_q   <= 1'b1;
          res_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.win_ready  = win_ready_q;
  assign bus.mac_clr    = mac_clr_q;
  assign bus.activation = act_q;
  assign bus.weight     = wgt_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_kernel = res_kernel_q;
  assign bus.dbg_state  = state_q;
  assign bus.dbg_tap    = tap_q;

endmodule

// File: tb/tb_sobel_window_feeder.sv
// Directed bench for sobel_window_feeder with a behavioural two-stage MAC,
// an expected-result queue and a handshake monitor.
module tb_sobel_window_feeder;
  import sobel_pkg::*;

  localparam int ACC_W = 32;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [ACC_W:0] exp_q [$];

  sobel_window_feeder_if #(.ACC_W(ACC_W)) bus ();

  sobel_window_feeder #(.MAC_LAT(2), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MAC model: product registered, then accumulated -> 2-cycle latency
  logic signed [15:0]      mac_prod;
  logic signed [ACC_W-1:0] mac_p1;
  logic signed [ACC_W-1:0] mac_acc;
  assign mac_prod       = $signed(bus.activation) * $signed(bus.weight);
  assign bus.mac_result = mac_acc;
  always_ff @(posedge clk) begin
    if (bus.mac_clr) begin
      mac_p1  <= '0;
      mac_acc <= '0;
    end else begin
      mac_p1  <= {{(ACC_W-16){mac_prod[15]}}, mac_prod};
      mac_acc <= mac_acc + mac_p1;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // scoreboard monitor: compare whenever a result transfers
  always @(negedge clk) begin
    #2;
    if (!reset && bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'(bus.res_data), 64'hDEAD);
      end else begin
        logic [ACC_W:0] e;
        e = exp_q.pop_front();
        check("res_data", 64'(bus.res_data), 64'(e[ACC_W-1:0]));
        check("res_kernel", 64'(bus.res_kernel), 64'(e[ACC_W]));
      end
    end
  end

  // driver: offer a window, return at the negedge of the CLEAR cycle
  task automatic issue(input logic [WIN_W-1:0] px, input logic sel,
                       input logic [ACC_W-1:0] want, input bit push);
    int n;
    @(negedge clk);
    bus.win_pixels = px;
    bus.kernel_sel = sel;
    bus.win_valid  = 1'b1;
    n = 0;
    while (!bus.win_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.win_ready) begin
      check("accept_timeout", 64'(n), 64'd0);
      bus.win_valid = 1'b0;
    end else begin
      if (push) exp_q.push_back({sel, want});
      @(posedge clk);
      @(negedge clk);
      bus.win_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(bus.dbg_state == IDLE && exp_q.size() == 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_timeout", 64'(n), 64'd0);
  endtask

  localparam logic [WIN_W-1:0] FLAT  = {9{8'd100}};
  localparam logic [WIN_W-1:0] VERT  = {3{24'hFE0000}};
  localparam logic [WIN_W-1:0] HORIZ = {48'h0, 24'hFEFEFE};
  localparam logic [WIN_W-1:0] RAMP  = {8'd80, 8'd70, 8'd60, 8'd50, 8'd40,
                                        8'd30, 8'd20, 8'd10, 8'd0};

  initial begin
    logic [7:0] exp_w [TAPS];
    int n;
    exp_w = '{8'hFF, 8'hFE, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h01};
    total = 0;
    bad   = 0;
    bus.win_valid  = 1'b0;
    bus.win_pixels = '0;
    bus.kernel_sel = 1'b0;
    bus.res_ready  = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_win_ready", 64'(bus.win_ready), 64'd1);
    check("rst_mac_clr", 64'(bus.mac_clr), 64'd1);
    check("rst_activation", 64'(bus.activation), 64'd0);
    check("rst_weight", 64'(bus.weight), 64'd0);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_res_data", 64'(bus.res_data), 64'd0);
    check("rst_state", 64'(bus.dbg_state), 64'(IDLE));
    reset = 1'b0;

    // flat window, with accept-to-valid latency
    issue(FLAT, 1'b0, 32'd0, 1'b1);
    n = 1;
    while (!bus.res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'd13);
    wait_idle();
    issue(FLAT, 1'b1, 32'd0, 1'b1);
    wait_idle();

    // vertical edge
    issue(VERT, 1'b0, 32'd508, 1'b1);
    wait_idle();
    issue(VERT, 1'b1, 32'd0, 1'b1);
    wait_idle();

    // horizontal edge, Gy, tap-by-tap weight and activation sequence
    issue(HORIZ, 1'b1, 32'hFFFFFE04, 1'b1);
    check("clear_mac_clr", 64'(bus.mac_clr), 64'd1);
    check("clear_weight", 64'(bus.weight), 64'd0);
    for (int k = 0; k < TAPS; k++) begin
      @(negedge clk);
      check($sformatf("tap%0d_weight", k), 64'(bus.weight), 64'(exp_w[k]));
      check($sformatf("tap%0d_act", k), 64'(bus.activation), (k < 3) ? 64'd127 : 64'd0);
      check($sformatf("tap%0d_mac_clr", k), 64'(bus.mac_clr), 64'd0);
    end
    wait_idle();

    // ramp window p_k = 10k
    issue(RAMP, 1'b0, 32'd40, 1'b1);
    wait_idle();
    issue(RAMP, 1'b1, 32'd120, 1'b1);
    wait_idle();

    // backpressure: result held for 5 cycles
    bus.res_ready = 1'b0;
    issue(VERT, 1'b0, 32'd508, 1'b1);
    n = 0;
    while (!bus.res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      check("bp_res_valid", 64'(bus.res_valid), 64'd1);
      check("bp_res_data", 64'(bus.res_data), 64'd508);
      check("bp_win_ready", 64'(bus.win_ready), 64'd0);
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("post_hs_win_ready", 64'(bus.win_ready), 64'd1);
    check("post_hs_res_valid", 64'(bus.res_valid), 64'd0);
    wait_idle();

    // async reset during tap 4, no partial result, then a clean window
    issue(FLAT, 1'b0, 32'd0, 1'b0);
    repeat (5) @(negedge clk);
    check("pre_reset_tap", 64'(bus.dbg_tap), 64'd4);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_state", 64'(bus.dbg_state), 64'(IDLE));
    check("mid_rst_win_ready", 64'(bus.win_ready), 64'd1);
    check("mid_rst_mac_clr", 64'(bus.mac_clr), 64'd1);
    check("mid_rst_activation", 64'(bus.activation), 64'd0);
    check("mid_rst_weight", 64'(bus.weight), 64'd0);
    check("mid_rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("mid_rst_res_data", 64'(bus.res_data), 64'd0);
    check("mid_rst_tap", 64'(bus.dbg_tap), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    issue(FLAT, 1'b0, 32'd0, 1'b1);
    wait_idle();

    // inputs keep changing while busy; the latched window must win
    issue(VERT, 1'b0, 32'd508, 1'b1);
    bus.win_valid = 1'b1;
    n = 0;
    while (!bus.res_valid && n < 40) begin
      bus.win_pixels = {9{8'(n * 37 + 5)}};
      bus.kernel_sel = n[0];
      check("busy_win_ready", 64'(bus.win_ready), 64'd0);
      @(negedge clk);
      n++;
    end
    bus.win_valid = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);
    check("final_state", 64'(bus.dbg_state), 64'(IDLE));
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0t want <200000", $time);
    $fatal(1, "timeout");
  end

endmodule
